// File: rtl/ieee80211_pkg.sv
// Shared 802.11a definitions: RATE codes, RATE -> NBPSC mapping and the
// interleaver geometry (NCBPS, step s, bit permutation).
package ieee80211_pkg;

    // SIGNAL-field RATE codes, R1 in the MSB.
    localparam logic [3:0] RATE_6M  = 4'b1101;
    localparam logic [3:0] RATE_9M  = 4'b1111;
    localparam logic [3:0] RATE_12M = 4'b0101;
    localparam logic [3:0] RATE_18M = 4'b0111;
    localparam logic [3:0] RATE_24M = 4'b1001;
    localparam logic [3:0] RATE_36M = 4'b1011;
    localparam logic [3:0] RATE_48M = 4'b0001;
    localparam logic [3:0] RATE_54M = 4'b0011;

    // One coded beat is 48 bits; a bank holds the largest symbol (64-QAM).
    localparam int BEAT_BITS = 48;
    localparam int BANK_BITS = 288;

    // Coded bits per subcarrier; unknown codes fall back to BPSK.
    function automatic logic [2:0] rate_to_nbpsc(input logic [3:0] rate);
        case (rate)
            RATE_6M,  RATE_9M:  return 3'd1;
            RATE_12M, RATE_18M: return 3'd2;
            RATE_24M, RATE_36M: return 3'd4;
            RATE_48M, RATE_54M: return 3'd6;
            default:            return 3'd1;
        endcase
    endfunction

    function automatic logic rate_is_valid(input logic [3:0] rate);
        case (rate)
            RATE_6M, RATE_9M, RATE_12M, RATE_18M,
            RATE_24M, RATE_36M, RATE_48M, RATE_54M: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

    // Permutation mode index (0..3) to NBPSC.
    function automatic int mode_nbpsc(input int mode);
        case (mode)
            0:       return 1;
            1:       return 2;
            2:       return 4;
            default: return 6;
        endcase
    endfunction

    function automatic int ncbps_of(input int nbpsc);
        return BEAT_BITS * nbpsc;
    endfunction

    function automatic int step_of(input int nbpsc);
        return (nbpsc / 2 > 1) ? nbpsc / 2 : 1;
    endfunction

    // Output position of input bit k (both permutations combined).
    function automatic int perm_pos(input int k, input int nbpsc);
        int ncbps;
        int s;
        int i;
        ncbps = ncbps_of(nbpsc);
        s     = step_of(nbpsc);
        i     = (ncbps / 16) * (k % 16) + k / 16;
        return s * (i / s) + (i + ncbps - (16 * i) / ncbps) % s;
    endfunction

endpackage

// File: rtl/interleaver_if.sv
// AXI-stream style beat bus used on both sides of the interleaver.
// A beat transfers on a rising clock edge where tvalid and tready are both 1;
// the master holds tdata/tuser/tlast stable while tvalid=1 and tready=0, and
// tvalid never depends on tready.
interface interleaver_if #(
    parameter int WIDTH = 48
) ();
    logic [WIDTH-1:0] tdata;
    logic             tvalid;
    logic             tready;
    logic             tlast;
    logic [3:0]       tuser;

    modport master (output tdata, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/interleaver_perm.sv
// Combinational 802.11a block interleaver map for one 288-bit bank.
// All four permutations are pure wiring; nbpsc selects one of them.
module interleaver_perm
    import ieee80211_pkg::*;
(
    input  logic [BANK_BITS-1:0] bank_in,
    input  logic [2:0]           nbpsc,
    output logic [BANK_BITS-1:0] bank_out
);

    logic [BANK_BITS-1:0] map [4];

    for (genvar m = 0; m < 4; m++) begin : g_mode
        localparam int NB = mode_nbpsc(m);
        localparam int NC = ncbps_of(NB);
        logic [BANK_BITS-1:0] perm_v;

        for (genvar k = 0; k < NC; k++) begin : g_bit
            assign perm_v[perm_pos(k, NB)] = bank_in[k];
        end
        if (NC < BANK_BITS) begin : g_pad
            assign perm_v[BANK_BITS-1:NC] = '0;
        end
        assign map[m] = perm_v;
    end

    // Pick the permutation for the bank's modulation.
    always_comb begin
        case (nbpsc)
            3'd2:    bank_out = map[1];
            3'd4:    bank_out = map[2];
            3'd6:    bank_out = map[3];
            default: bank_out = map[0];
        endcase
    end

endmodule

// File: rtl/interleaver.sv
// 802.11a interleaver with two ping-pong symbol banks: one fills from the
// encoder while the other drains through the permutation.
// Optional rate checking (err port) is enabled by INTERLEAVER_RATE_CHECK_EN.
module interleaver
    import ieee80211_pkg::*;
#(
    parameter int WIDTH = 48
) (
    input  logic          aclk,
    input  logic          areset,
    interleaver_if.slave  s_axis,
    interleaver_if.master m_axis
`ifdef INTERLEAVER_RATE_CHECK_EN
    ,
    output logic          err
`endif
);

    if (WIDTH != BEAT_BITS) begin : g_width_check
        $error("interleaver: only WIDTH=48 is supported");
    end

    logic [BANK_BITS-1:0] bank_q [2];
    logic [3:0]           rate_q [2];
    logic [2:0]           nb_q   [2];
    logic [1:0]           full_q;
    logic [1:0]           last_q;
    logic                 wr_sel, rd_sel;
    logic [2:0]           wr_cnt, rd_cnt;
    logic                 s_hs, m_hs, m_valid;
    logic                 wr_first, wr_close, rd_done;
    logic [2:0]           wr_nb;
    logic [BANK_BITS-1:0] perm_out;

    // Handshakes and symbol boundaries; a bank emptied this cycle may be refilled at once.
    always_comb begin
        wr_first      = (wr_cnt == 3'd0);
        wr_nb         = wr_first ? rate_to_nbpsc(s_axis.tuser) : nb_q[wr_sel];
        m_valid       = !areset && full_q[rd_sel];
        m_hs          = m_valid && m_axis.tready;
        rd_done       = m_hs && (rd_cnt == nb_q[rd_sel] - 3'd1);
        s_axis.tready = !areset && (!full_q[wr_sel] || (rd_done && (rd_sel == wr_sel)));
        s_hs          = s_axis.tvalid && s_axis.tready;
        wr_close      = s_hs && (s_axis.tlast || (wr_cnt == wr_nb - 3'd1));
    end

    // Bank control: fill/drain pointers, beat counters and full flags.
    always_ff @(posedge aclk) begin
        if (areset) begin
            full_q <= '0;
            last_q <= '0;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
            wr_cnt <= 3'd0;
            rd_cnt <= 3'd0;
        end else begin
            if (s_hs) begin
                if (wr_close) begin
                    wr_cnt         <= 3'd0;
                    wr_sel         <= !wr_sel;
                    last_q[wr_sel] <= s_axis.tlast;
                end else begin
                    wr_cnt <= wr_cnt + 3'd1;
                end
            end
            if (rd_done) begin
                rd_cnt         <= 3'd0;
                rd_sel         <= !rd_sel;
                full_q[rd_sel] <= 1'b0;
            end else if (m_hs) begin
                rd_cnt <= rd_cnt + 3'd1;
            end
            // Set after clear: a bank drained and refilled in one cycle stays full.
            if (wr_close) begin
                full_q[wr_sel] <= 1'b1;
            end
        end
    end

    // Bank data; the first beat zero-fills the rest so early-closed symbols are padded.
    always_ff @(posedge aclk) begin
        if (s_hs) begin
            if (wr_first) begin
                bank_q[wr_sel] <= BANK_BITS'(s_axis.tdata);
                rate_q[wr_sel] <= s_axis.tuser;
                nb_q[wr_sel]   <= wr_nb;
            end else begin
                bank_q[wr_sel][int'(wr_cnt) * WIDTH +: WIDTH] <= s_axis.tdata;
            end
        end
    end

    interleaver_perm u_perm (
        .bank_in  (bank_q[rd_sel]),
        .nbpsc    (nb_q[rd_sel]),
        .bank_out (perm_out)
    );

    // Output beat from the draining bank; all zero when nothing is valid.
    always_comb begin
        m_axis.tvalid = m_valid;
        m_axis.tdata  = '0;
        m_axis.tuser  = '0;
        m_axis.tlast  = 1'b0;
        if (m_valid) begin
            m_axis.tdata = perm_out[int'(rd_cnt) * WIDTH +: WIDTH];
            m_axis.tuser = rate_q[rd_sel];
            m_axis.tlast = last_q[rd_sel] && (rd_cnt == nb_q[rd_sel] - 3'd1);
        end
    end

`ifdef INTERLEAVER_RATE_CHECK_EN
    // Sticky flag: invalid RATE on a first beat, or RATE changing mid-symbol.
    always_ff @(posedge aclk) begin
        if (areset) begin
            err <= 1'b0;
        end else if (s_hs && (wr_first ? !rate_is_valid(s_axis.tuser)
                                       : (s_axis.tuser != rate_q[wr_sel]))) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_interleaver.sv
// Bench for the 802.11a interleaver: reference vectors, random symbols against
// a formula model, throughput, backpressure and reset-mid-symbol sequences.
module tb_interleaver;
    import ieee80211_pkg::*;

    localparam int W = 48;

    typedef struct {
        logic [3:0]  rate;
        int          n_in;
        logic [47:0] din0;
        logic        tl;
        int          n_out;
        logic [47:0] dout0;
    } vec_t;

    logic aclk       = 1'b0;
    logic areset     = 1'b1;
    logic ready_val  = 1'b1;
    logic rand_ready = 1'b0;
    logic rnd_bit    = 1'b1;

    int checks    = 0;
    int failures  = 0;
    int stall_cnt = 0;
    logic [52:0] exp_q [$];
    vec_t vecs [8];

    interleaver_if #(.WIDTH(W)) s_if ();
    interleaver_if #(.WIDTH(W)) m_if ();

    assign m_if.tready = rand_ready ? rnd_bit : ready_val;

`ifdef INTERLEAVER_RATE_CHECK_EN
    logic err;
    interleaver #(.WIDTH(W)) dut (
        .aclk(aclk), .areset(areset), .s_axis(s_if), .m_axis(m_if), .err(err)
    );
`else
    interleaver #(.WIDTH(W)) dut (
        .aclk(aclk), .areset(areset), .s_axis(s_if), .m_axis(m_if)
    );
`endif

    // Clock
    always #5 aclk = ~aclk;

    // Random sink readiness, changed just after each rising edge
    always @(posedge aclk) begin
        #1 rnd_bit = 1'($urandom_range(0, 1));
    end

    function automatic int tb_nbpsc(input logic [3:0] r);
        case (r)
            RATE_6M,  RATE_9M:  return 1;
            RATE_12M, RATE_18M: return 2;
            RATE_24M, RATE_36M: return 4;
            RATE_48M, RATE_54M: return 6;
            default:            return 1;
        endcase
    endfunction

    function automatic logic [287:0] model_perm(input logic [287:0] din, input int nb);
        int ncbps, s, i, j;
        logic [287:0] dout;
        ncbps = 48 * nb;
        s     = (nb / 2 > 1) ? nb / 2 : 1;
        dout  = '0;
        for (int k = 0; k < ncbps; k++) begin
            i = (ncbps / 16) * (k % 16) + k / 16;
            j = s * (i / s) + (i + ncbps - (16 * i) / ncbps) % s;
            dout[j] = din[k];
        end
        return dout;
    endfunction

    function automatic logic [47:0] rand48();
        return 48'({$urandom, $urandom});
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Driver: present one beat and hold it until accepted (bounded)
    task automatic send_beat(input logic [47:0] d, input logic [3:0] u, input logic l);
        int n;
        n = 0;
        s_if.tdata  = d;
        s_if.tuser  = u;
        s_if.tlast  = l;
        s_if.tvalid = 1'b1;
        @(negedge aclk);
        while (!s_if.tready && n < 200) begin
            @(negedge aclk);
            n++;
        end
        stall_cnt += n;
        if (!s_if.tready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout data=%0h waited=%0d cycles", d, n);
        end
        step();
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    // Push model output beats, then drive the symbol's input beats
    task automatic send_symbol(input logic [3:0] r, input logic [287:0] din, input int n_in,
                               input logic tl, input bit junk_user);
        int nb;
        logic [287:0] dout;
        nb   = tb_nbpsc(r);
        dout = model_perm(din, nb);
        for (int b = 0; b < nb; b++)
            exp_q.push_back({tl && (b == nb - 1), r, dout[b*48 +: 48]});
        for (int b = 0; b < n_in; b++)
            send_beat(din[b*48 +: 48], (b == 0 || !junk_user) ? r : 4'($urandom_range(0, 15)),
                      tl && (b == n_in - 1));
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check("drain_remaining", 64'(exp_q.size()), 0);
    endtask

    // Scoreboard: compare each output handshake and stability under stall
    task automatic monitor();
        logic [52:0] got, exp, held;
        logic held_v;
        held_v = 1'b0;
        held   = '0;
        forever begin
            @(negedge aclk);
            got = {m_if.tlast, m_if.tuser, m_if.tdata};
            if (held_v && !areset)
                check("hold_stable", 64'({m_if.tvalid, got}), 64'({1'b1, held}));
            if (!areset && m_if.tvalid && m_if.tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out got=%0h exp=none", got);
                end else begin
                    exp = exp_q.pop_front();
                    check("out_beat", 64'(got), 64'(exp));
                end
            end
            held_v = !areset && m_if.tvalid && !m_if.tready;
            held   = got;
        end
    endtask

    task automatic run_tests();
        logic [3:0] rates [9];
        logic [287:0] din;
        logic [3:0] r;
        logic tl;
        int nb, n_in;

        vecs[0] = '{RATE_6M,  1, 48'h000000000001, 1'b0, 1, 48'h000000000001};
        vecs[1] = '{RATE_6M,  1, 48'h000000000002, 1'b0, 1, 48'h000000000008};
        vecs[2] = '{RATE_6M,  1, 48'h000000010000, 1'b0, 1, 48'h000000000002};
        vecs[3] = '{RATE_12M, 2, 48'h000000000002, 1'b0, 2, 48'h000000000040};
        vecs[4] = '{RATE_24M, 4, 48'h000000000002, 1'b0, 4, 48'h000000002000};
        vecs[5] = '{RATE_12M, 1, 48'h000000000002, 1'b1, 2, 48'h000000000040};
        vecs[6] = '{RATE_54M, 6, 48'h000000000002, 1'b0, 6, 48'h000000100000};
        vecs[7] = '{4'h0,     1, 48'h000000000002, 1'b0, 1, 48'h000000000008};
        rates   = '{RATE_6M, RATE_9M, RATE_12M, RATE_18M, RATE_24M,
                    RATE_36M, RATE_48M, RATE_54M, 4'h0};

        // Reset state
        repeat (3) step();
        @(negedge aclk);
        check("rst_s_tready", 64'(s_if.tready), 0);
        check("rst_m_tvalid", 64'(m_if.tvalid), 0);
        check("rst_m_tdata",  64'(m_if.tdata),  0);
        check("rst_m_tuser",  64'(m_if.tuser),  0);
        check("rst_m_tlast",  64'(m_if.tlast),  0);
        step();
        areset = 1'b0;
        @(negedge aclk);
        check("ready_after_reset", 64'(s_if.tready), 1);
        step();

        // Reference vectors
        for (int v = 0; v < 8; v++) begin
            for (int b = 0; b < vecs[v].n_out; b++)
                exp_q.push_back({vecs[v].tl && (b == vecs[v].n_out - 1), vecs[v].rate,
                                 (b == 0) ? vecs[v].dout0 : 48'h0});
            for (int b = 0; b < vecs[v].n_in; b++)
                send_beat((b == 0) ? vecs[v].din0 : 48'h0, vecs[v].rate,
                          vecs[v].tl && (b == vecs[v].n_in - 1));
            wait_drain(50);
        end

        // Random symbols, random early tlast, random sink stalls
        rand_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            r    = rates[$urandom_range(0, 8)];
            nb   = tb_nbpsc(r);
            n_in = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, nb)) : nb;
            tl   = (n_in < nb) ? 1'b1 : 1'($urandom_range(0, 1));
            din  = '0;
            for (int b = 0; b < n_in; b++) din[b*48 +: 48] = rand48();
            send_symbol(r, din, n_in, tl, 1'b1);
        end
        wait_drain(2000);
        rand_ready = 1'b0;
        ready_val  = 1'b1;

        // Back-to-back symbols with a free sink never stall the source
        stall_cnt = 0;
        for (int g = 0; g < 4; g++) begin
            r  = rates[(g == 0) ? 0 : (g == 1) ? 2 : (g == 2) ? 4 : 7];
            nb = tb_nbpsc(r);
            for (int n = 0; n < 3; n++) begin
                din = '0;
                for (int b = 0; b < nb; b++) din[b*48 +: 48] = rand48();
                send_symbol(r, din, nb, 1'b0, 1'b0);
            end
            wait_drain(100);
        end
        check("no_stall_streaming", 64'(stall_cnt), 0);

        // Backpressure: sink stalled 10 cycles, two symbols fill both banks
        ready_val = 1'b0;
        send_symbol(RATE_6M, 288'(rand48()), 1, 1'b0, 1'b0);
        send_symbol(RATE_6M, 288'(rand48()), 1, 1'b0, 1'b0);
        for (int c = 0; c < 8; c++) begin
            @(negedge aclk);
            check("bp_s_tready_low", 64'(s_if.tready), 0);
            check("bp_m_tvalid_high", 64'(m_if.tvalid), 1);
            step();
        end
        ready_val = 1'b1;
        @(negedge aclk);
        check("bank_reuse_same_cycle", 64'(s_if.tready), 1);
        step();
        for (int n = 0; n < 4; n++) send_symbol(RATE_6M, 288'(rand48()), 1, 1'b0, 1'b0);
        wait_drain(50);

        // Reset in the middle of a 54M symbol
        for (int b = 0; b < 3; b++) send_beat(rand48(), RATE_54M, 1'b0);
        areset = 1'b1;
        @(negedge aclk);
        check("mid_rst_s_tready", 64'(s_if.tready), 0);
        check("mid_rst_m_tvalid", 64'(m_if.tvalid), 0);
        step();
        areset = 1'b0;
        @(negedge aclk);
        check("mid_rst_ready_after", 64'(s_if.tready), 1);
        for (int c = 0; c < 5; c++) begin
            check("mid_rst_no_output", 64'(m_if.tvalid), 0);
            step();
            @(negedge aclk);
        end
        step();
        din = '0;
        for (int b = 0; b < 6; b++) din[b*48 +: 48] = rand48();
        send_symbol(RATE_54M, din, 6, 1'b1, 1'b0);
        wait_drain(50);
    endtask

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tuser  = '0;
        s_if.tlast  = 1'b0;
        fork
            run_tests();
            monitor();
            begin
                repeat (40000) @(posedge aclk);
                checks++;
                failures++;
                $display("FAIL watchdog cycles=40000 exp=finish_earlier");
            end
        join_any
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
